// File: rtl/wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_dual_master_arbiter
// Description : Round-robin arbiter sharing one Wishbone slave port between
//               two Wishbone masters. The grant is registered and locked for
//               the owner's whole CYC tenure. A per-tenure watchdog ends
//               stalled beats with a single-cycle error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dual_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DW-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DW-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic              s_ack_i,
    input  logic [DW-1:0]     s_dat_i,

    output logic [1:0]        gnt_o
);

    // State codes double as the one-hot grant vector, so gnt_o is the
    // state register itself.
    localparam logic [1:0]  c_S_IDLE   = 2'b00;
    localparam logic [1:0]  c_S_GNT0   = 2'b01;
    localparam logic [1:0]  c_S_GNT1   = 2'b10;

    // Watchdog count at which a still-unacknowledged strobe is killed.
    localparam logic [15:0] c_WD_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_WD_MAX   = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last;        // 1: m1 owned the bus last (or reset) -> m0 wins ties
    logic [15:0] r_wd_cnt;

    logic        w_own0;
    logic        w_own1;
    logic        w_own_cyc;
    logic        w_own_stb;
    logic        w_release;
    logic        w_timeout;

    assign w_own0    = (r_state == c_S_GNT0);
    assign w_own1    = (r_state == c_S_GNT1);
    assign w_own_cyc = w_own0 ? m0_cyc_i : (w_own1 ? m1_cyc_i : 1'b0);
    assign w_own_stb = w_own0 ? m0_stb_i : (w_own1 ? m1_stb_i : 1'b0);

    // Owner drops CYC: the grant ends at this edge.
    assign w_release = (w_own0 | w_own1) & ~w_own_cyc;

    // A same-cycle ACK always beats the watchdog.
    assign w_timeout = (w_own0 | w_own1) & w_own_stb & ~s_ack_i
                     & (r_wd_cnt == c_WD_LIMIT);

    // Next-state: round-robin grant from IDLE, hold while the owner keeps CYC.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next_state = r_last ? c_S_GNT0 : c_S_GNT1;
                end else if (m0_cyc_i) begin
                    w_next_state = c_S_GNT0;
                end else if (m1_cyc_i) begin
                    w_next_state = c_S_GNT1;
                end
            end
            c_S_GNT0: begin
                if (!m0_cyc_i) begin
                    w_next_state = c_S_IDLE;
                end
            end
            c_S_GNT1: begin
                if (!m1_cyc_i) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // State register; async reset drops the grant (and with it every s_* output).
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember which master released the bus most recently.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_last <= 1'b1;
        end else if (w_release) begin
            r_last <= w_own1;
        end
    end

    // Watchdog: counts consecutive stalled strobe cycles of the current owner.
    // It is held at zero in IDLE, so every new grant starts from zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wd_cnt <= 16'd0;
        end else if ((r_state == c_S_IDLE) || w_release) begin
            r_wd_cnt <= 16'd0;
        end else if (w_timeout || s_ack_i || !w_own_stb) begin
            r_wd_cnt <= 16'd0;
        end else if (r_wd_cnt != c_WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    // Output routing: the owner's request goes to the slave, the slave's
    // response goes only to the owner; everything is zero while IDLE.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (w_own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~w_timeout;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i & m0_stb_i;
            m0_err_o = w_timeout;
            m0_dat_o = s_dat_i;
        end else if (w_own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~w_timeout;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i & m1_stb_i;
            m1_err_o = w_timeout;
            m1_dat_o = s_dat_i;
        end
    end

    assign gnt_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dual_master_arbiter
// Description : Self-checking bench for wb_dual_master_arbiter: vector table,
//               directed corner sequences and random traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dual_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [SW-1:0] m0_sel;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat, m0_rdat;
    logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [SW-1:0] m1_sel;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat, m1_rdat;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [SW-1:0] s_sel;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;
    logic [1:0]    gnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),
        .m0_cyc_i (m0_cyc),  .m0_stb_i (m0_stb),  .m0_we_i (m0_we),
        .m0_sel_i (m0_sel),  .m0_adr_i (m0_adr),  .m0_dat_i(m0_wdat),
        .m0_ack_o (m0_ack),  .m0_err_o (m0_err),  .m0_dat_o(m0_rdat),
        .m1_cyc_i (m1_cyc),  .m1_stb_i (m1_stb),  .m1_we_i (m1_we),
        .m1_sel_i (m1_sel),  .m1_adr_i (m1_adr),  .m1_dat_i(m1_wdat),
        .m1_ack_o (m1_ack),  .m1_err_o (m1_err),  .m1_dat_o(m1_rdat),
        .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),   .s_we_o  (s_we),
        .s_sel_o  (s_sel),   .s_adr_o  (s_adr),   .s_dat_o (s_wdat),
        .s_ack_i  (s_ack),   .s_dat_i  (s_rdat),
        .gnt_o    (gnt)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_adr = '0; m1_wdat = '0;
        s_ack  = 1'b0; s_rdat = '0;
    endtask

    // Drive point: just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner/last/stall bookkeeping per transaction rules
    // ------------------------------------------------------------------
    int mdl_owner;   // -1 when nobody owns the bus
    int mdl_last;
    int mdl_stall;

    task automatic model_reset();
        mdl_owner = -1;
        mdl_last  = 1;
        mdl_stall = 0;
    endtask

    function automatic logic [140:0] model_expect();
        logic [1:0]    g;
        logic          sc, ss, swe, a0, e0, a1, e1, to, stb;
        logic [SW-1:0] ssel;
        logic [AW-1:0] sadr;
        logic [DW-1:0] sdat, r0, r1;
        g = 2'b00; sc = 1'b0; ss = 1'b0; swe = 1'b0; ssel = '0; sadr = '0; sdat = '0;
        a0 = 1'b0; e0 = 1'b0; r0 = '0; a1 = 1'b0; e1 = 1'b0; r1 = '0;
        if (mdl_owner >= 0) begin
            stb = (mdl_owner == 0) ? m0_stb : m1_stb;
            to  = stb && !s_ack && (mdl_stall == TO - 1);
            if (mdl_owner == 0) begin
                g = 2'b01; sc = m0_cyc; ss = m0_stb && !to; swe = m0_we;
                ssel = m0_sel; sadr = m0_adr; sdat = m0_wdat;
                a0 = s_ack && m0_stb; e0 = to; r0 = s_rdat;
            end else begin
                g = 2'b10; sc = m1_cyc; ss = m1_stb && !to; swe = m1_we;
                ssel = m1_sel; sadr = m1_adr; sdat = m1_wdat;
                a1 = s_ack && m1_stb; e1 = to; r1 = s_rdat;
            end
        end
        return {g, sc, ss, swe, ssel, sadr, sdat, a0, e0, r0, a1, e1, r1};
    endfunction

    task automatic model_step();
        logic own_cyc, own_stb;
        if (mdl_owner < 0) begin
            mdl_stall = 0;
            if (m0_cyc && m1_cyc) mdl_owner = 1 - mdl_last;
            else if (m0_cyc)      mdl_owner = 0;
            else if (m1_cyc)      mdl_owner = 1;
        end else begin
            own_cyc = (mdl_owner == 0) ? m0_cyc : m1_cyc;
            own_stb = (mdl_owner == 0) ? m0_stb : m1_stb;
            if (!own_cyc) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
                mdl_stall = 0;
            end else if (s_ack || !own_stb || mdl_stall == TO - 1) begin
                mdl_stall = 0;
            end else begin
                mdl_stall++;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        c0, s0, c1, s1, ack;
        logic [1:0]  gnt;
        logic        scyc, sstb, a0, a1;
        logic [31:0] d0;
    } vec_t;

    localparam int NV = 17;
    localparam logic [31:0] RD = 32'hCAFE_0001;
    vec_t tbl [NV];

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0] seq [$];
        logic [1:0] prev;
        int n_err, first_err, gnt_bad, beats_ok, slow;
        logic stb_k7, stb_k8, ack0_seen, ack1_seen;

        //          rst   c0    s0    c1    s1    ack   gnt    scyc  sstb  a0    a1    d0
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, RD};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, RD};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, RD};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, RD};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, RD};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, RD};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, RD};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        clear_inputs();
        do_reset();
        @(negedge clk);
        chk("reset_outputs", {gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, m0_rdat, m1_rdat}, '0);

        // Table: single read from m0, tie from reset, m1 single read
        next_cycle();
        for (int i = 0; i < NV; i++) begin
            rst_n  = !tbl[i].rst;
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_adr = 32'h10;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; m1_adr = 32'h20;
            s_ack  = tbl[i].ack; s_rdat = RD;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_rdat},
                {tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].a0, tbl[i].a1, tbl[i].d0});
            if (i == 2) chk("vec2_s_adr", s_adr, 160'h10);
            next_cycle();
        end
        rst_n = 1'b1;

        // Both masters hammer single beats: grants must alternate
        do_reset();
        s_ack = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        prev = 2'b00;
        seq.delete();
        for (int c = 0; c < 200 && seq.size() < 8; c++) begin
            @(negedge clk);
            if (gnt != 2'b00 && gnt != prev) seq.push_back(gnt);
            prev = gnt;
            ack0_seen = m0_ack;
            ack1_seen = m1_ack;
            next_cycle();
            m0_cyc = !ack0_seen; m0_stb = !ack0_seen;
            m1_cyc = !ack1_seen; m1_stb = !ack1_seen;
        end
        chk("alt_grant_count", seq.size(), 8);
        for (int k = 0; k < seq.size(); k++)
            chk($sformatf("alt_grant%0d", k), seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        clear_inputs();

        // m1 holds CYC for 8 beats while m0 waits
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        next_cycle();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        beats_ok = 0;
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk);
            if (gnt == 2'b10 && m1_ack && !m0_ack) beats_ok++;
            next_cycle();
            if (b == 8) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
        end
        chk("burst_beats", beats_ok, 8);
        @(negedge clk);
        chk("burst_release_cycle", {gnt, m0_ack}, {2'b10, 1'b0});
        next_cycle();
        @(negedge clk);
        chk("burst_idle_gap", gnt, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("burst_m0_granted", {gnt, m0_ack}, {2'b01, 1'b1});
        clear_inputs();

        // Watchdog: slave never acks m0
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        n_err = 0; first_err = -1; gnt_bad = 0; stb_k7 = 1'b0; stb_k8 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            if (m0_err) begin n_err++; if (first_err < 0) first_err = k; end
            if (m1_err) n_err += 100;
            if (k == 7) stb_k7 = s_stb;
            if (k == 8) stb_k8 = s_stb;
            if (gnt != ((k == 0) ? 2'b00 : 2'b01)) gnt_bad++;
        end
        chk("wd_err_pulses", n_err, 1);
        chk("wd_err_cycle", first_err, 8);
        chk("wd_stb_before", stb_k7, 1'b1);
        chk("wd_stb_killed", stb_k8, 1'b0);
        chk("wd_grant_held", gnt_bad, 0);
        next_cycle();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        chk("wd_drop_cycle", gnt, 2'b01);
        next_cycle();
        @(negedge clk);
        chk("wd_after_drop", gnt, 2'b00);

        // Async reset mid-beat under GNT1 after m0 had last ownership
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        next_cycle();                       // GNT0, beat acked
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        next_cycle();                       // release cycle -> IDLE
        next_cycle();                       // IDLE -> GNT1 at next edge
        next_cycle();
        chk("rst_pre_gnt1", {gnt, s_cyc, s_stb}, {2'b10, 1'b1, 1'b1});
        m0_cyc = 1'b1; m0_stb = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("rst_async_drop", {gnt, s_cyc, s_stb, m1_ack}, '0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_first_contest", gnt, 2'b01);
        clear_inputs();

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            slow = ((c / 500) % 2 == 1) ? 1 : 0;
            if ($urandom_range(0, slow ? 19 : 4) == 0) m0_cyc = !m0_cyc;
            if ($urandom_range(0, slow ? 19 : 4) == 0) m1_cyc = !m1_cyc;
            m0_stb  = m0_cyc && ($urandom_range(0, 7) != 0);
            m1_stb  = m1_cyc && ($urandom_range(0, 7) != 0);
            m0_we   = 1'($urandom); m1_we = 1'($urandom);
            m0_sel  = SW'($urandom); m1_sel = SW'($urandom);
            m0_adr  = $urandom; m1_adr = $urandom;
            m0_wdat = $urandom; m1_wdat = $urandom;
            s_ack   = ($urandom_range(0, slow ? 11 : 3) == 0);
            s_rdat  = $urandom;
            @(negedge clk);
            chk("rand_cycle",
                {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat,
                 m0_ack, m0_err, m0_rdat, m1_ack, m1_err, m1_rdat},
                model_expect());
            model_step();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
